simmem_release_scheduler: RTL and testbench

Schedules when buffered messages in the simulated-memory message bank may leave it. It holds up to NumSlots pending (ID, delay) entries, counts each delay down, and grants expired entries one at a time, round-robin. The grant drives the bank's per-ID release-enable mask. It sits between the request-side delay calculator and the message bank / response output.

---
 rtl/simmem_pkg.sv | 21 ++
 rtl/simmem_rr_arbiter.sv | 41 ++++
 rtl/simmem_release_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_simmem_release_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared types and default parameters for the simulated-memory release scheduler.
package simmem_pkg;

    localparam int unsigned DefNumSlots   = 8;
    localparam int unsigned DefIDWidth    = 4;
    localparam int unsigned DefDelayWidth = 8;

    typedef enum logic [1:0] {
        SlotFree     = 2'd0,
        SlotCounting = 2'd1,
        SlotGranted  = 2'd2
    } slot_state_e;

    // Default-width view of one pending-release slot.
    typedef struct packed {
        logic [DefIDWidth-1:0]    id;
        logic [DefDelayWidth-1:0] counter;
        slot_state_e              state;
    } slot_t;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr_i, else lowest request.
module simmem_rr_arbiter #(
    parameter int unsigned NumSlots = 8,
    parameter int unsigned IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
    input  logic [NumSlots-1:0] req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [NumSlots-1:0] gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                valid_o
);

    logic                w_hi_valid;
    logic [IdxWidth-1:0] w_hi_idx;
    logic [IdxWidth-1:0] w_lo_idx;

    always_comb begin
        gnt_o      = '0;
        idx_o      = '0;
        valid_o    = 1'b0;
        w_hi_valid = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                w_lo_idx = IdxWidth'(i);
                if (IdxWidth'(i) >= ptr_i) begin
                    w_hi_valid = 1'b1;
                    w_hi_idx   = IdxWidth'(i);
                end
            end
        end
        valid_o = |req_i;
        idx_o   = w_hi_valid ? w_hi_idx : w_lo_idx;
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Delays buffered messages per entry and grants expired ones round-robin, one at a time.
// Optional statistics ports are enabled by defining SIMMEM_RELEASE_STATS_EN.
module simmem_release_scheduler
    import simmem_pkg::*;
#(
    parameter int unsigned NumSlots   = DefNumSlots,
    parameter int unsigned IDWidth    = DefIDWidth,
    parameter int unsigned DelayWidth = DefDelayWidth
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [IDWidth-1:0]              in_id_i,
    input  logic [DelayWidth-1:0]           in_delay_i,
    output logic                            release_valid_o,
    input  logic                            release_ready_i,
    output logic [IDWidth-1:0]              release_id_o,
    output logic [2**IDWidth-1:0]           release_en_o,
`ifdef SIMMEM_RELEASE_STATS_EN
    output logic [31:0]                     released_cnt_o,
    output logic [$clog2(NumSlots+1)-1:0]   max_occupancy_o,
`endif
    output logic [$clog2(NumSlots+1)-1:0]   occupancy_o
);

    localparam int unsigned IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int unsigned OccWidth = $clog2(NumSlots + 1);

    typedef struct packed {
        logic [IDWidth-1:0]    id;
        logic [DelayWidth-1:0] counter;
        slot_state_e           state;
    } slot_entry_t;

    slot_entry_t         r_slots [NumSlots];
    // r_age[i][j] set: slot j holds an entry accepted before the one in slot i.
    logic [NumSlots-1:0] r_age   [NumSlots];
    logic                r_lock;
    logic [IdxWidth-1:0] r_lock_idx;
    logic [IdxWidth-1:0] r_rr_ptr;

    logic [NumSlots-1:0] w_occupied;
    logic [NumSlots-1:0] w_req;
    logic [NumSlots-1:0] w_alloc_oh;
    logic [NumSlots-1:0] w_arb_gnt;
    logic [NumSlots-1:0] w_rel_oh;
    logic [IdxWidth-1:0] w_arb_idx;
    logic [IdxWidth-1:0] w_rel_idx;
    logic [OccWidth-1:0] w_occ;
    logic                w_arb_valid;
    logic                w_rel_valid;
    logic                w_accept;
    logic                w_handshake;

    always_comb begin
        w_occupied = '0;
        w_occ      = '0;
        for (int i = 0; i < int'(NumSlots); i++) begin
            w_occupied[i] = (r_slots[i].state != SlotFree);
            w_occ         = w_occ + OccWidth'(w_occupied[i]);
        end
    end

    // An expired entry waits while any older entry with the same ID is still pending,
    // so the bank's per-ID FIFO order is preserved.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < int'(NumSlots); i++) begin
            w_req[i] = (r_slots[i].state == SlotCounting) && (r_slots[i].counter == '0);
            for (int j = 0; j < int'(NumSlots); j++) begin
                if (w_occupied[j] && r_age[i][j] && (r_slots[j].id == r_slots[i].id)) begin
                    w_req[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_alloc_oh = '0;
        for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
            if (!w_occupied[i]) begin
                w_alloc_oh    = '0;
                w_alloc_oh[i] = 1'b1;
            end
        end
    end

    simmem_rr_arbiter #(
        .NumSlots (NumSlots),
        .IdxWidth (IdxWidth)
    ) u_arbiter (
        .req_i   (w_req),
        .ptr_i   (r_rr_ptr),
        .gnt_o   (w_arb_gnt),
        .idx_o   (w_arb_idx),
        .valid_o (w_arb_valid)
    );

    assign in_ready_o  = ~&w_occupied;
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_rel_valid = r_lock | w_arb_valid;
    assign w_rel_idx   = r_lock ? r_lock_idx : w_arb_idx;
    assign w_rel_oh    = r_lock ? (NumSlots'(1) << r_lock_idx) : w_arb_gnt;
    assign w_handshake = w_rel_valid & release_ready_i;

    assign release_valid_o = w_rel_valid;
    assign release_id_o    = w_rel_valid ? r_slots[w_rel_idx].id : '0;
    assign occupancy_o     = w_occ;

    always_comb begin
        release_en_o = '0;
        if (w_rel_valid) begin
            release_en_o[release_id_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumSlots); i++) begin
                r_slots[i].id      <= '0;
                r_slots[i].counter <= '0;
                r_slots[i].state   <= SlotFree;
                r_age[i]           <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NumSlots); i++) begin
                if ((r_slots[i].state == SlotCounting) && (r_slots[i].counter != '0)) begin
                    r_slots[i].counter <= r_slots[i].counter - 1'b1;
                end
                if (w_handshake && w_rel_oh[i]) begin
                    r_slots[i].state <= SlotFree;
                end else if (!r_lock && w_arb_gnt[i]) begin
                    r_slots[i].state <= SlotGranted;
                end
                if (w_accept && w_alloc_oh[i]) begin
                    r_slots[i].id      <= in_id_i;
                    r_slots[i].counter <= in_delay_i;
                    r_slots[i].state   <= SlotCounting;
                    r_age[i]           <= w_occupied;
                end
                // Column clears come last so they override the row load above.
                for (int j = 0; j < int'(NumSlots); j++) begin
                    if ((w_accept && w_alloc_oh[j]) || (w_handshake && w_rel_oh[j])) begin
                        r_age[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else if (w_handshake) begin
            r_lock   <= 1'b0;
            r_rr_ptr <= (w_rel_idx == IdxWidth'(NumSlots - 1)) ? '0 : w_rel_idx + 1'b1;
        end else if (!r_lock && w_arb_valid) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_arb_idx;
        end
    end

`ifdef SIMMEM_RELEASE_STATS_EN
    logic [31:0]         r_released_cnt;
    logic [OccWidth-1:0] r_max_occ;
    logic [OccWidth-1:0] w_max_occ;

    assign w_max_occ       = (w_occ > r_max_occ) ? w_occ : r_max_occ;
    assign released_cnt_o  = r_released_cnt;
    assign max_occupancy_o = w_max_occ;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_released_cnt <= '0;
            r_max_occ      <= '0;
        end else begin
            r_max_occ <= w_max_occ;
            if (w_handshake) begin
                r_released_cnt <= r_released_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Self-checking bench for simmem_release_scheduler; release IDs are checked against a scoreboard.
module tb_simmem_release_scheduler;

    localparam int unsigned NumSlots   = 8;
    localparam int unsigned IDWidth    = 4;
    localparam int unsigned DelayWidth = 8;
    localparam int unsigned OccWidth   = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [IDWidth-1:0]    in_id_i;
    logic [DelayWidth-1:0] in_delay_i;
    logic                  release_valid_o;
    logic                  release_ready_i;
    logic [IDWidth-1:0]    release_id_o;
    logic [15:0]           release_en_o;
    logic [OccWidth-1:0]   occupancy_o;
`ifdef SIMMEM_RELEASE_STATS_EN
    logic [31:0]           released_cnt_o;
    logic [OccWidth-1:0]   max_occupancy_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [IDWidth-1:0] sb[$];
    logic [IDWidth-1:0] sb_exp;

    always #5 clk_i = ~clk_i;

    simmem_release_scheduler #(
        .NumSlots   (NumSlots),
        .IDWidth    (IDWidth),
        .DelayWidth (DelayWidth)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_id_i         (in_id_i),
        .in_delay_i      (in_delay_i),
        .release_valid_o (release_valid_o),
        .release_ready_i (release_ready_i),
        .release_id_o    (release_id_o),
        .release_en_o    (release_en_o),
`ifdef SIMMEM_RELEASE_STATS_EN
        .released_cnt_o  (released_cnt_o),
        .max_occupancy_o (max_occupancy_o),
`endif
        .occupancy_o     (occupancy_o)
    );

    // Every completed handshake must match the oldest outstanding expected release.
    always @(negedge clk_i) begin
        if (!rst_i && release_valid_o && release_ready_i) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got release id %0d, required no release", release_id_o);
            end else begin
                sb_exp = sb.pop_front();
                if (release_id_o !== sb_exp || release_en_o !== (16'h1 << sb_exp)) begin
                    n_fail++;
                    $display("FAIL sb_release: got id %0d en %h, required id %0d en %h",
                             release_id_o, release_en_o, sb_exp, 16'h1 << sb_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IDWidth-1:0] id,
                         input logic [DelayWidth-1:0] d);
        in_valid_i = v;
        in_id_i    = id;
        in_delay_i = d;
    endtask

    task automatic reset_dut();
        rst_i           = 1'b1;
        release_ready_i = 1'b0;
        drive(1'b0, '0, '0);
        sb.delete();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk_i);
        n_tests++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready_o);
        end
        n_tests++;
        if (release_valid_o !== 1'b0 || release_id_o !== '0 || release_en_o !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got valid %b id %0d en %h, required 0 0 0000",
                     release_valid_o, release_id_o, release_en_o);
        end
        n_tests++;
        if (occupancy_o !== '0) begin
            n_fail++; $display("FAIL reset_occ: got %0d, required 0", occupancy_o);
        end
    endtask

    task automatic test_min_latency();
        reset_dut();
        release_ready_i = 1'b1;
        drive(1'b1, 4'd3, 8'd0);
        sb.push_back(4'd3);
        @(negedge clk_i);
        n_tests++;
        if (release_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL minlat_c0_valid: got %b, required 0", release_valid_o);
        end
        tick();
        drive(1'b0, '0, '0);
        @(negedge clk_i);
        n_tests++;
        if (release_valid_o !== 1'b1 || release_en_o !== 16'h0008 || occupancy_o !== 4'd1) begin
            n_fail++;
            $display("FAIL minlat_c1: got valid %b en %h occ %0d, required 1 0008 1",
                     release_valid_o, release_en_o, occupancy_o);
        end
        tick();
        @(negedge clk_i);
        n_tests++;
        if (occupancy_o !== 4'd0 || release_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL minlat_c2: got occ %0d valid %b, required 0 0", occupancy_o,
                     release_valid_o);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        drive(1'b1, 4'd1, 8'd5);
        sb.push_back(4'd1);
        for (int c = 1; c <= 11; c++) begin
            tick();
            drive(1'b0, '0, '0);
            release_ready_i = (c == 10);
            @(negedge clk_i);
            n_tests++;
            if (c <= 5) begin
                if (release_valid_o !== 1'b0) begin
                    n_fail++; $display("FAIL bp_early c%0d: got valid %b, required 0", c,
                                       release_valid_o);
                end
            end else if (c <= 10) begin
                if (release_valid_o !== 1'b1 || release_id_o !== 4'd1) begin
                    n_fail++; $display("FAIL bp_hold c%0d: got valid %b id %0d, required 1 1", c,
                                       release_valid_o, release_id_o);
                end
            end else if (occupancy_o !== 4'd0 || release_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_freed: got occ %0d valid %b, required 0 0",
                                   occupancy_o, release_valid_o);
            end
        end
    endtask

    task automatic test_full();
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            drive(1'b1, IDWidth'(i), 8'd2);
            sb.push_back(IDWidth'(i));
        end
        tick();
        // Offer while full: must be ignored.
        drive(1'b1, 4'd9, 8'd0);
        release_ready_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (in_ready_o !== 1'b0 || occupancy_o !== 4'd8) begin
            n_fail++; $display("FAIL full_state: got ready %b occ %0d, required 0 8", in_ready_o,
                               occupancy_o);
        end
        tick();
        drive(1'b0, '0, '0);
        release_ready_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (in_ready_o !== 1'b1 || occupancy_o !== 4'd7) begin
            n_fail++; $display("FAIL full_after_free: got ready %b occ %0d, required 1 7",
                               in_ready_o, occupancy_o);
        end
        release_ready_i = 1'b1;
        for (int k = 0; k < 20 && occupancy_o != 0; k++) begin
            tick();
            @(negedge clk_i);
        end
        n_tests++;
        if (occupancy_o !== 4'd0 || sb.size() != 0) begin
            n_fail++; $display("FAIL full_drain: got occ %0d pending %0d, required 0 0",
                               occupancy_o, sb.size());
        end
`ifdef SIMMEM_RELEASE_STATS_EN
        n_tests++;
        if (released_cnt_o !== 32'd8 || max_occupancy_o !== 4'd8) begin
            n_fail++; $display("FAIL full_stats: got cnt %0d max %0d, required 8 8",
                               released_cnt_o, max_occupancy_o);
        end
`endif
    endtask

    task automatic test_round_robin();
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            drive(1'b1, IDWidth'(i), DelayWidth'(7 - i));
            sb.push_back(IDWidth'(i));
        end
        for (int c = 8; c <= 21; c++) begin
            tick();
            drive(1'b0, '0, '0);
            release_ready_i = 1'b1;
            if (c == 16) begin drive(1'b1, 4'd5, 8'd3); sb.push_back(4'd5); end
            if (c == 17) begin drive(1'b1, 4'd6, 8'd2); sb.push_back(4'd6); end
            @(negedge clk_i);
            n_tests++;
            if (c <= 15) begin
                if (release_valid_o !== 1'b1 || release_id_o !== IDWidth'(c - 8)) begin
                    n_fail++; $display("FAIL rr_order c%0d: got valid %b id %0d, required 1 %0d",
                                       c, release_valid_o, release_id_o, c - 8);
                end
            end else if (c <= 19) begin
                if (release_valid_o !== 1'b0) begin
                    n_fail++; $display("FAIL rr_idle c%0d: got valid %b, required 0", c,
                                       release_valid_o);
                end
            end else begin
                if (release_valid_o !== 1'b1 ||
                    release_id_o !== ((c == 20) ? 4'd5 : 4'd6)) begin
                    n_fail++; $display("FAIL rr_wrap c%0d: got valid %b id %0d, required 1 %0d",
                                       c, release_valid_o, release_id_o, (c == 20) ? 5 : 6);
                end
            end
        end
    endtask

    task automatic test_same_id_order();
        reset_dut();
        release_ready_i = 1'b1;
        drive(1'b1, 4'd2, 8'd10);
        sb.push_back(4'd2);
        tick();
        drive(1'b1, 4'd2, 8'd0);
        sb.push_back(4'd2);
        for (int c = 2; c <= 13; c++) begin
            tick();
            drive(1'b0, '0, '0);
            @(negedge clk_i);
            n_tests++;
            if (c <= 10) begin
                if (release_valid_o !== 1'b0) begin
                    n_fail++; $display("FAIL sameid_blocked c%0d: got valid %b, required 0", c,
                                       release_valid_o);
                end
            end else if (c <= 12) begin
                if (release_valid_o !== 1'b1 || occupancy_o !== OccWidth'(13 - c)) begin
                    n_fail++; $display("FAIL sameid_release c%0d: got valid %b occ %0d, required 1 %0d",
                                       c, release_valid_o, occupancy_o, 13 - c);
                end
            end else if (occupancy_o !== 4'd0) begin
                n_fail++; $display("FAIL sameid_empty: got occ %0d, required 0", occupancy_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        release_ready_i = 1'b1;
        drive(1'b1, 4'd4, 8'd0);
        sb.push_back(4'd4);
        tick();
        drive(1'b1, 4'd6, 8'd1);
        sb.push_back(4'd6);
        tick();
        drive(1'b0, '0, '0);
        release_ready_i = 1'b0;
        tick();
        tick();
        @(negedge clk_i);
        n_tests++;
        if (release_valid_o !== 1'b1 || release_id_o !== 4'd6) begin
            n_fail++; $display("FAIL midrst_locked: got valid %b id %0d, required 1 6",
                               release_valid_o, release_id_o);
        end
`ifdef SIMMEM_RELEASE_STATS_EN
        n_tests++;
        if (released_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL midrst_cnt_pre: got %0d, required 1", released_cnt_o);
        end
`endif
        #2;
        rst_i = 1'b1;
        #1;
        n_tests++;
        if (release_valid_o !== 1'b0 || occupancy_o !== 4'd0 || in_ready_o !== 1'b1 ||
            release_en_o !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: got valid %b occ %0d ready %b en %h, required 0 0 1 0000",
                     release_valid_o, occupancy_o, in_ready_o, release_en_o);
        end
`ifdef SIMMEM_RELEASE_STATS_EN
        n_tests++;
        if (released_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL midrst_cnt: got %0d, required 0", released_cnt_o);
        end
`endif
        reset_dut();
        release_ready_i = 1'b1;
        drive(1'b1, 4'd7, 8'd0);
        sb.push_back(4'd7);
        tick();
        drive(1'b0, '0, '0);
        @(negedge clk_i);
        n_tests++;
        if (release_valid_o !== 1'b1 || release_id_o !== 4'd7) begin
            n_fail++; $display("FAIL midrst_recover: got valid %b id %0d, required 1 7",
                               release_valid_o, release_id_o);
        end
        tick();
    endtask

    initial begin
        rst_i           = 1'b1;
        release_ready_i = 1'b0;
        drive(1'b0, '0, '0);
        test_reset();
        test_min_latency();
        test_backpressure();
        test_full();
        test_round_robin();
        test_same_id_order();
        test_reset_mid();
        @(negedge clk_i);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
